// File: rtl/fg_multi_waveform_gen_pkg.sv
// fg_pkg: shared definitions for the multi-channel slope generator.
//   fg_state_e : slope FSM state encoding (IDLE=0, RISE=1, ON=2, FALL=3)
//   ch_idx_w   : width of a channel index for a given channel count (min 1)
//   cfg_w      : width of one packed config record
//                {period, on, k_rise, k_fall, amp, en, invert}
package fg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } fg_state_e;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cfg_w(input int cb, input int w);
    return 2 * cb + 3 * w + 2;
  endfunction

endpackage

// File: rtl/fg_multi_waveform_gen_if.sv
// Config write port of fg_multi_waveform_gen.
//   cfg_valid/cfg_ready : handshake
//   cfg_ch              : target channel
//   cfg_period/cfg_on   : last counter value of the period / fall start count
//   cfg_k_rise/k_fall   : unsigned rise and fall steps
//   cfg_amp             : amplitude
//   cfg_en/cfg_invert   : channel enable / output amp-val
// Handshake: a write transfers on every clock edge where cfg_valid and
// cfg_ready are both high. cfg_ready is combinational from cfg_ch (it is low
// only while the addressed channel still holds an uncommitted write), so the
// master may change cfg_ch while waiting; it must hold the payload stable
// while cfg_valid is high and cfg_ready is low.
interface fg_multi_waveform_gen_if import fg_pkg::*; #(
  parameter int CHANNELS          = 2,
  parameter int COUNTER_BITWIDTH  = 32,
  parameter int WAVEFORM_BITWIDTH = 16
);
  localparam int CHW = ch_idx_w(CHANNELS);

  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [CHW-1:0]               cfg_ch;
  logic [COUNTER_BITWIDTH-1:0]  cfg_period;
  logic [COUNTER_BITWIDTH-1:0]  cfg_on;
  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_rise;
  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_fall;
  logic [WAVEFORM_BITWIDTH-1:0] cfg_amp;
  logic                         cfg_en;
  logic                         cfg_invert;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_on, cfg_k_rise, cfg_k_fall,
           cfg_amp, cfg_en, cfg_invert,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_on, cfg_k_rise, cfg_k_fall,
           cfg_amp, cfg_en, cfg_invert,
    output cfg_ready
  );

endinterface

// File: rtl/fg_slope_channel.sv
// One generator channel: active config registers, period counter, slope FSM,
// clamped accumulator, invert and period_start pulse.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   clk_en_i, sync_i : sample tick, phase realign (sampled on ticks only)
//   pending_i        : shadow_i holds an uncommitted write
//   shadow_i         : packed {period, on, k_rise, k_fall, amp, en, invert}
//   commit_o         : shadow is copied into the active registers this cycle
//   out_o            : registered sample {1'b0, invert ? amp-val : val}
//   period_start_o   : registered pulse on the tick the counter becomes 0
//   state_o          : current FSM state (debug)
module fg_slope_channel import fg_pkg::*; #(
  parameter int CB = 32,
  parameter int W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_i,
  input  logic                  sync_i,
  input  logic                  pending_i,
  input  logic [2*CB+3*W+1:0]   shadow_i,
  output logic                  commit_o,
  output logic [W:0]            out_o,
  output logic                  period_start_o,
  output logic [1:0]            state_o
);
  localparam logic [CB-1:0] CNT_ONE = 1;

  fg_state_e     state_q, state_d;
  logic [CB-1:0] cnt_q, cnt_d, period_q, period_d, on_q, on_d;
  logic [W-1:0]  val_q, val_d, kr_q, kr_d, kf_q, kf_d, amp_q, amp_d;
  logic          en_q, en_d, inv_q, inv_d, ps_q, ps_d;
  logic [W:0]    out_q, out_d;
  logic [W:0]    rise_sum;
  logic          wrap;

  always_comb begin
    period_d = period_q;
    on_d     = on_q;
    kr_d     = kr_q;
    kf_d     = kf_q;
    amp_d    = amp_q;
    en_d     = en_q;
    inv_d    = inv_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    ps_d     = 1'b0;
    wrap     = sync_i || (cnt_q == period_q);
    // The sum is one bit wider so an overflowing step still clamps to amp.
    rise_sum = {1'b0, val_q} + {1'b0, kr_q};
    // A disabled channel takes new config on any cycle; a running one only
    // at its period boundary so the waveform never glitches mid-period.
    commit_o = pending_i && (!en_q || (clk_en_i && wrap));

    if (commit_o) begin
      {period_d, on_d, kr_d, kf_d, amp_d, en_d, inv_d} = shadow_i;
    end

    if (!en_q) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      val_d   = '0;
    end else if (clk_en_i) begin
      ps_d  = wrap;
      cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
      // Transitions use the pre-update counter and value.
      case (state_q)
        ST_IDLE: if (cnt_q == '0) state_d = ST_RISE;
        ST_RISE: begin
          if (cnt_q == on_q)          state_d = ST_FALL;
          else if (val_q == amp_q)    state_d = ST_ON;
          else if (cnt_q == period_q) state_d = ST_IDLE;
        end
        ST_ON: begin
          if (cnt_q == '0)        state_d = ST_RISE;
          else if (cnt_q == on_q) state_d = ST_FALL;
        end
        ST_FALL: begin
          if (cnt_q == '0)      state_d = ST_RISE;
          else if (val_q == '0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      // The value follows the state being entered.
      case (state_d)
        ST_IDLE: val_d = '0;
        ST_RISE: val_d = (rise_sum > {1'b0, amp_q}) ? amp_q : rise_sum[W-1:0];
        ST_ON:   val_d = amp_q;
        ST_FALL: val_d = (val_q < kf_q) ? '0 : val_q - kf_q;
        default: val_d = '0;
      endcase
    end

    out_d          = {1'b0, inv_q ? amp_q - val_q : val_q};
    out_o          = out_q;
    period_start_o = ps_q;
    state_o        = state_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      val_q    <= '0;
      period_q <= '0;
      on_q     <= '0;
      kr_q     <= '0;
      kf_q     <= '0;
      amp_q    <= '0;
      en_q     <= 1'b0;
      inv_q    <= 1'b0;
      ps_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      period_q <= period_d;
      on_q     <= on_d;
      kr_q     <= kr_d;
      kf_q     <= kf_d;
      amp_q    <= amp_d;
      en_q     <= en_d;
      inv_q    <= inv_d;
      ps_q     <= ps_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: rtl/fg_multi_waveform_gen.sv
// Multi-channel trapezoid/triangle waveform generator.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clk_en_i       : sample-rate tick
//   sync_i         : on a tick, realign every enabled channel to counter 0
//   cfg            : config write port (slave side)
//   out_o          : channel n at [n*(W+1) +: W+1], MSB always 0
//   period_start_o : per-channel registered period-start pulse
//   dbg_state_o    : channel n FSM state at [2*n +: 2]
// Holds the per-channel shadow/pending registers and the write demux;
// each channel decides itself when its shadow may be committed.
module fg_multi_waveform_gen import fg_pkg::*; #(
  parameter int CHANNELS          = 2,
  parameter int COUNTER_BITWIDTH  = 32,
  parameter int WAVEFORM_BITWIDTH = 16
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         clk_en_i,
  input  logic                                         sync_i,
  fg_multi_waveform_gen_if.slave                       cfg,
  output logic [CHANNELS*(WAVEFORM_BITWIDTH+1)-1:0]    out_o,
  output logic [CHANNELS-1:0]                          period_start_o,
  output logic [2*CHANNELS-1:0]                        dbg_state_o
);
  localparam int CB   = COUNTER_BITWIDTH;
  localparam int W    = WAVEFORM_BITWIDTH;
  localparam int CFGW = cfg_w(CB, W);

  logic [CHANNELS-1:0][CFGW-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0]           pending_q, pending_d, commit;
  logic                          ch_ok, accept;

  always_comb begin
    // Writes to a channel index that does not exist are swallowed.
    ch_ok         = int'(cfg.cfg_ch) < CHANNELS;
    cfg.cfg_ready = 1'b1;
    if (ch_ok) cfg.cfg_ready = !pending_q[cfg.cfg_ch];
    accept    = cfg.cfg_valid && cfg.cfg_ready && ch_ok;
    shadow_d  = shadow_q;
    // accept requires pending clear, so it never races a commit.
    pending_d = pending_q & ~commit;
    if (accept) begin
      shadow_d[cfg.cfg_ch]  = {cfg.cfg_period, cfg.cfg_on, cfg.cfg_k_rise,
                               cfg.cfg_k_fall, cfg.cfg_amp, cfg.cfg_en,
                               cfg.cfg_invert};
      pending_d[cfg.cfg_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      pending_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    fg_slope_channel #(.CB(CB), .W(W)) u_ch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clk_en_i       (clk_en_i),
      .sync_i         (sync_i),
      .pending_i      (pending_q[n]),
      .shadow_i       (shadow_q[n]),
      .commit_o       (commit[n]),
      .out_o          (out_o[n*(W+1) +: W+1]),
      .period_start_o (period_start_o[n]),
      .state_o        (dbg_state_o[2*n +: 2])
    );
  end

endmodule

// File: tb/tb_fg_multi_waveform_gen.sv
// Self-checking bench for fg_multi_waveform_gen (3 channels).
module tb_fg_multi_waveform_gen;
  import fg_pkg::*;

  localparam int NCH = 3;
  localparam int CB  = 32;
  localparam int W   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, clk_en, sync;
  logic [NCH*(W+1)-1:0] out;
  logic [NCH-1:0]       ps;
  logic [2*NCH-1:0]     dbg;

  always #5 clk = ~clk;

  fg_multi_waveform_gen_if #(.CHANNELS(NCH), .COUNTER_BITWIDTH(CB),
                             .WAVEFORM_BITWIDTH(W)) bus ();

  fg_multi_waveform_gen #(.CHANNELS(NCH), .COUNTER_BITWIDTH(CB),
                          .WAVEFORM_BITWIDTH(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_en_i       (clk_en),
    .sync_i         (sync),
    .cfg            (bus),
    .out_o          (out),
    .period_start_o (ps),
    .dbg_state_o    (dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint period;
    longint on;
    int     kr;
    int     kf;
    int     amp;
    bit     en;
    bit     inv;
  } cfg_t;

  cfg_t   m_sh[NCH], m_act[NCH];
  bit     m_pend[NCH];
  longint m_cnt[NCH];
  int     m_st[NCH];   // 0 idle, 1 rise, 2 on, 3 fall
  int     m_val[NCH];
  int     m_out[NCH];
  bit     m_ps[NCH];

  task automatic model_reset();
    cfg_t z;
    z = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
    for (int c = 0; c < NCH; c++) begin
      m_sh[c] = z; m_act[c] = z; m_pend[c] = 0; m_cnt[c] = 0;
      m_st[c] = 0; m_val[c] = 0; m_out[c] = 0; m_ps[c] = 0;
    end
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   acc, commit, wrap;
    int   ns, v;
    int   ch;
    cfg_t a;
    if (rst) begin
      model_reset();
      return;
    end
    ch  = int'(bus.cfg_ch);
    acc = bus.cfg_valid && (ch < NCH) && !m_pend[ch];
    for (int c = 0; c < NCH; c++) begin
      a = m_act[c];
      m_out[c] = a.inv ? ((a.amp - m_val[c]) & 'hFFFF) : m_val[c];
      commit = m_pend[c] && (!a.en || (clk_en && (sync || m_cnt[c] == a.period)));
      if (!a.en) begin
        m_cnt[c] = 0; m_st[c] = 0; m_val[c] = 0; m_ps[c] = 0;
      end else if (clk_en) begin
        wrap = sync || (m_cnt[c] == a.period);
        ns = m_st[c];
        if (m_st[c] == 0) begin
          if (m_cnt[c] == 0) ns = 1;
        end else if (m_st[c] == 1) begin
          if (m_cnt[c] == a.on) ns = 3;
          else if (m_val[c] == a.amp) ns = 2;
          else if (m_cnt[c] == a.period) ns = 0;
        end else if (m_st[c] == 2) begin
          if (m_cnt[c] == 0) ns = 1;
          else if (m_cnt[c] == a.on) ns = 3;
        end else begin
          if (m_cnt[c] == 0) ns = 1;
          else if (m_val[c] == 0) ns = 0;
        end
        if (ns == 0)      v = 0;
        else if (ns == 1) v = (m_val[c] + a.kr > a.amp) ? a.amp : m_val[c] + a.kr;
        else if (ns == 2) v = a.amp;
        else              v = (m_val[c] - a.kf < 0) ? 0 : m_val[c] - a.kf;
        m_st[c]  = ns;
        m_val[c] = v;
        m_cnt[c] = wrap ? 0 : ((m_cnt[c] + 1) & 64'hFFFF_FFFF);
        m_ps[c]  = wrap;
      end else begin
        m_ps[c] = 0;
      end
      if (commit) begin
        m_act[c]  = m_sh[c];
        m_pend[c] = 0;
      end
    end
    if (acc) begin
      m_sh[ch] = '{longint'(bus.cfg_period), longint'(bus.cfg_on),
                   int'(bus.cfg_k_rise), int'(bus.cfg_k_fall),
                   int'(bus.cfg_amp), bus.cfg_en, bus.cfg_invert};
      m_pend[ch] = 1;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("out%0d", c), 64'(out[c*(W+1) +: W+1]), 64'(m_out[c]));
      check($sformatf("ps%0d", c), 64'(ps[c]), 64'(m_ps[c]));
      check($sformatf("state%0d", c), 64'(dbg[2*c +: 2]), 64'(m_st[c]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; checks ready, advances the model,
  // waits for the next edge and compares all outputs.
  task automatic cycle();
    bit exp_ready;
    #1;
    if (int'(bus.cfg_ch) >= NCH) exp_ready = 1;
    else exp_ready = !m_pend[int'(bus.cfg_ch)];
    check("ready", 64'(bus.cfg_ready), 64'(exp_ready));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_cfg(input int ch, input int per, input int on,
                         input int kr, input int kf, input int amp,
                         input bit en, input bit inv);
    bus.cfg_valid  = 1'b1;
    bus.cfg_ch     = ch[1:0];
    bus.cfg_period = CB'(per);
    bus.cfg_on     = CB'(on);
    bus.cfg_k_rise = W'(kr);
    bus.cfg_k_fall = W'(kf);
    bus.cfg_amp    = W'(amp);
    bus.cfg_en     = en;
    bus.cfg_invert = inv;
  endtask

  task automatic write_cfg(input int ch, input int per, input int on,
                           input int kr, input int kf, input int amp,
                           input bit en, input bit inv);
    set_cfg(ch, per, on, kr, kf, amp, en, inv);
    cycle();
    bus.cfg_valid = 1'b0;
  endtask

  function automatic int ch_out(input int c);
    return int'(out[c*(W+1) +: W+1]);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int val;
    bit ps;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int pat[10];
    int pre_max, post_max, guard;
    pat = '{4, 8, 10, 10, 10, 7, 4, 1, 0, 0};
    // Entry i: ch0 output after tick i+2 shows the value of tick i+1;
    // period_start shows tick i+2, which wraps every 10th tick.
    for (int i = 0; i < 20; i++) begin
      tbl[i].val = pat[i % 10];
      tbl[i].ps  = (i % 10) == 8;
    end

    rst = 1'b1; clk_en = 1'b0; sync = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_on = '0;
    bus.cfg_k_rise = '0; bus.cfg_k_fall = '0; bus.cfg_amp = '0;
    bus.cfg_en = 1'b0; bus.cfg_invert = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 64'(out), 64'd0);
    check("rst_ps", 64'(ps), 64'd0);
    check("rst_state", 64'(dbg), 64'd0);
    check("rst_ready", 64'(bus.cfg_ready), 64'd1);
    rst = 1'b0;

    // Basic trapezoid on ch0.
    write_cfg(0, 9, 5, 4, 3, 10, 1'b1, 1'b0);
    cycle();
    clk_en = 1'b1;
    cycle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("tbl_val", 64'(ch_out(0)), 64'(tbl[i].val));
      check("tbl_ps", 64'(ps[0]), 64'(tbl[i].ps));
    end

    // Mid-period amplitude rewrite, plus a stalled second write.
    set_cfg(0, 9, 5, 4, 3, 6, 1'b1, 1'b0);
    cycle();
    check("stall_ready", 64'(bus.cfg_ready), 64'd0);
    cycle();
    bus.cfg_valid = 1'b0;
    pre_max = 0;
    guard = 0;
    while (!ps[0] && guard < 30) begin
      cycle();
      if (ch_out(0) > pre_max) pre_max = ch_out(0);
      guard++;
    end
    check("wrap_seen", 64'(ps[0]), 64'd1);
    check("pre_peak", 64'(pre_max), 64'd10);
    check("ready_after_commit", 64'(bus.cfg_ready), 64'd1);
    post_max = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (ch_out(0) > post_max) post_max = ch_out(0);
    end
    check("post_peak", 64'(post_max), 64'd6);

    // Triangle on ch2: fall starts at cnt 3 from 6 and clamps at 0.
    write_cfg(2, 9, 3, 2, 4, 100, 1'b1, 1'b0);
    cycle();
    cycle();
    exp_q = '{16'd2, 16'd4, 16'd6, 16'd2, 16'd0, 16'd0};
    while (exp_q.size() > 0) begin
      cycle();
      check("tri", 64'(ch_out(2)), 64'(exp_q.pop_front()));
    end

    // Invert: realign ch0/ch1 from a disabled start, ch1 inverted.
    write_cfg(0, 9, 5, 4, 3, 6, 1'b0, 1'b0);
    idle(12);
    clk_en = 1'b0;
    write_cfg(0, 9, 5, 4, 3, 10, 1'b1, 1'b0);
    write_cfg(1, 9, 5, 4, 3, 10, 1'b1, 1'b1);
    cycle();
    clk_en = 1'b1;
    cycle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("inv_ch0", 64'(ch_out(0)), 64'(tbl[i].val));
      check("inv_ch1", 64'(ch_out(1)), 64'(10 - tbl[i].val));
    end

    // Sync: offset ch1, then realign everything with a pending ch2 write.
    write_cfg(1, 9, 5, 4, 3, 10, 1'b0, 1'b1);
    idle(11);
    write_cfg(1, 9, 5, 4, 3, 10, 1'b1, 1'b1);
    idle(5);
    guard = 0;
    while (m_cnt[0] != 7 && guard < 30) begin
      cycle();
      guard++;
    end
    check("sync_wait_bound", 64'(guard < 30), 64'd1);
    clk_en = 1'b0;
    write_cfg(2, 9, 3, 2, 4, 50, 1'b1, 1'b0);
    check("sync_pending_ready", 64'(bus.cfg_ready), 64'd0);
    clk_en = 1'b1;
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check("sync_ps", 64'(ps), 64'h7);
    check("sync_commit_ready", 64'(bus.cfg_ready), 64'd1);
    idle(15);

    // Sparse ticks, then reset in the middle of a rise.
    guard = 0;
    for (int i = 0; i < 90; i++) begin
      clk_en = (i % 3) == 0;
      cycle();
      guard++;
      if (clk_en && m_st[0] == 1 && i > 10) break;
    end
    check("rise_wait_bound", 64'(guard < 90), 64'd1);
    rst = 1'b1; sync = 1'b1; clk_en = 1'b1;
    set_cfg(1, 5, 2, 1, 1, 9, 1'b1, 1'b0);
    cycle();
    rst = 1'b0; sync = 1'b0; clk_en = 1'b0;
    bus.cfg_valid = 1'b0;
    check("post_rst_out", 64'(out), 64'd0);
    check("post_rst_ps", 64'(ps), 64'd0);
    check("post_rst_state", 64'(dbg), 64'd0);
    check("post_rst_ready", 64'(bus.cfg_ready), 64'd1);

    // Write to a channel that does not exist.
    set_cfg(NCH, 9, 5, 4, 3, 10, 1'b1, 1'b1);
    check("bad_ch_ready", 64'(bus.cfg_ready), 64'd1);
    cycle();
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = 2'd0;
    idle(3);
    check("bad_ch_drop_out", 64'(out), 64'd0);
    check("bad_ch_drop_ready", 64'(bus.cfg_ready), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst    = $urandom_range(0, 199) == 0;
      clk_en = $urandom_range(0, 3) != 0;
      sync   = $urandom_range(0, 29) == 0;
      set_cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 14),
              ($urandom_range(0, 6) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 20),
              ($urandom_range(0, 6) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 20),
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 40),
              $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)));
      bus.cfg_valid = $urandom_range(0, 2) == 0;
      cycle();
    end
    rst = 1'b0; sync = 1'b0; bus.cfg_valid = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fg_multi_waveform_gen.md
# fg_multi_waveform_gen

Multi-channel trapezoid/triangle waveform generator, the parametrised successor of the single-channel slope generator in the function-generator datapath. Each of `CHANNELS` channels owns a period counter, a four-state slope FSM and a clamped slope accumulator. Each channel is configured through a shared valid/ready write port into per-channel shadow registers; shadow values commit glitch-free at that channel's period boundary. Outputs feed the DAC/mixer stage at the `clk_en_i` sample rate.

## Interface
- `CHANNELS`, 2, number of independent generator channels (1..16)
- `COUNTER_BITWIDTH`, 32, width of period/ON counters
- `WAVEFORM_BITWIDTH`, 16, width of amplitude, slopes and sample values
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset: one clock; reset is synchronous and active-high
- `clk_en_i`  in  1  sample-rate tick; all state advances only when high
- `sync_i`  in  1  on a tick, forces every enabled channel to counter 0 (phase realign)
- `cfg_valid_i` / `cfg_ready_o`  in/out  1  config write handshake
- `cfg_ch_i`  in  clog2(CHANNELS) (min 1)  target channel
- `cfg_period_i`, `cfg_on_i`  in  COUNTER_BITWIDTH  last counter value of the period; counter value at which fall starts
- `cfg_k_rise_i`, `cfg_k_fall_i`, `cfg_amp_i`  in  WAVEFORM_BITWIDTH  unsigned rise step, fall step, amplitude
- `cfg_en_i`, `cfg_invert_i`  in  1  channel enable; output amp−val instead of val
- `out_o`  out  CHANNELS*(WAVEFORM_BITWIDTH+1)  channel n at bits [n*(W+1) +: W+1], MSB always 0
- `period_start_o`  out  CHANNELS  per-channel one-cycle pulse, registered, on the tick the counter becomes 0

## Operation
- Write accepted when `cfg_valid_i && cfg_ready_o`; the fields land in shadow[cfg_ch_i] and set pending[cfg_ch_i].
- `cfg_ready_o = !pending[cfg_ch_i]`. This is combinational from `cfg_ch_i`. If `cfg_ch_i >= CHANNELS`, ready is 1 and the write is dropped.
- Commit copies shadow to active and clears pending. It happens on a tick where the channel counter wraps (cnt==period) or `sync_i`=1, or on any cycle (tick not required) while the active enable is 0.
- Counter, on tick with active enable: `sync_i` → 0; else cnt==period → 0; else cnt+1. If period is 0, every tick is a wrap.
- Disabled channel: cnt=0, state IDLE, val=0 each cycle.
- FSM, evaluated on tick with the pre-update cnt and val:
  - IDLE: → RISE when cnt==0.
  - RISE: the first matching condition wins:
    - cnt==on → FALL
    - val==amp → ON
    - cnt==period → IDLE
  - ON: cnt==0 → RISE; else cnt==on → FALL.
  - FALL: cnt==0 → RISE; else val==0 → IDLE.
- Accumulator, using the W+1-bit zero-extended sum (no sign extension of k):
  - IDLE: val=0.
  - RISE: val=min(val+k_rise, amp).
  - ON: val=amp.
  - FALL: val = val−k_fall, or 0 if that would be negative.
- Output: `out_o[n]` = {1'b0, invert ? amp−val : val}. It uses the active amp and is registered.
- amp=0: RISE → ON on its first evaluation. k_rise=0 with on>period: the channel stays in RISE/IDLE at 0.
- `sync_i` is sampled only on ticks; without `clk_en_i` it has no effect.

## Timing
- Reset: all counters, vals, active/shadow registers, pending, `out_o`, and `period_start_o` are 0. `cfg_ready_o`=1. State is IDLE.
- Latency:
  - FSM/val change is visible on `out_o` one clock after the tick.
  - A committed config affects the FSM from the next tick.
- Back-to-back writes to different channels are accepted every cycle. A same-channel rewrite stalls until that channel's commit.
- `rst_i` mid-operation overrides commit, `sync_i` and config writes in the same cycle.

## Structure
- Shared package `fg_pkg`: state encoding (IDLE=0, RISE=1, ON=2, FALL=3) and the channel-index width function.
- Sub-module `fg_slope_channel`: one channel's active regs, counter, FSM, accumulator, invert and `period_start`. It is instantiated `CHANNELS` times via generate.
- Top level: config demux, shadow/pending registers, ready logic.

## Test plan
- Reset, then ch0 config (period=9, on=5, k_rise=4, k_fall=3, amp=10, en=1), `clk_en_i`=1 → ch0 ticks: IDLE 0 → RISE 4, 8, 10 → ON 10 → FALL 7, 4, 1, 0 → IDLE; repeats with period 10 ticks; `period_start_o[0]` pulses every 10 ticks.
- Rewrite ch0 amp=6 mid-period → no change until the wrap, then peak 6; a second ch0 write before the wrap sees `cfg_ready_o`=0.
- Triangle (on=3, k_rise=2, amp=100) → FALL starts at cnt 3 from val 6 (never reaches ON); FALL clamps at 0 with k_fall=4 (6, 2, 0).
- ch1 invert=1, amp=10, same profile as ch0 → `out_o[1]` = 10−ch0 value each cycle; ch0 unaffected.
- `sync_i` with ch0 at cnt 7 and ch1 at cnt 2 → both counters 0 on the same tick, both `period_start_o` bits pulse together, pending commits applied.
- `clk_en_i` every 3rd cycle plus `rst_i` asserted mid-RISE → outputs hold between ticks; everything is 0 one cycle after `rst_i`; `cfg_ch_i`=CHANNELS write is dropped with ready=1.
